serial_subtractor: RTL

- Word-framed, bit-serial subtractor: computes A − B − bin on two LSB-first serial operand streams of WIDTH bits.
- It is the inverse-operation companion to the team's bit-serial adder.
- Emits each difference bit serially with a running borrow flop, and assembles the full difference word and final borrow for parallel readout.
- Sits between the serial operand sources and any parallel consumer of results.

---
 rtl/serial_subtractor.sv | 126 ++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Word-framed bit-serial subtractor: A - B - bin on LSB-first streams, with
// serial difference/borrow outputs and a parallel result word on done.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             a,
    input  logic             b,
    input  logic             bin,
    output logic             d,
    output logic             bout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff_word,
    output logic             borrow_word,
    output logic             overrun
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [WIDTH-1:0] diff_nxt;
    logic             d_nxt;
    logic             bout_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             borrow_nxt;
    logic             overrun_nxt;

    logic take_bit;
    logic first_bit;
    logic last_bit;
    logic br;
    logic bit_d;
    logic bit_br;

    // Full-subtractor cell; bit 0 borrows from bin, later bits from bout
    always_comb begin
        first_bit = (state != RUN);
        take_bit  = (state == RUN) || start;
        last_bit  = (state == RUN) && (cnt == CW'(WIDTH - 1));
        br        = first_bit ? bin : bout;
        bit_d     = a ^ b ^ br;
        bit_br    = (~a & b) | (~(a ^ b) & br);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = last_bit ? DONE : RUN;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A start seen in RUN is plain data for framing purposes; only overrun notes it
    always_comb begin
        d_nxt       = d;
        bout_nxt    = bout;
        shreg_nxt   = shreg;
        cnt_nxt     = cnt;
        diff_nxt    = diff_word;
        borrow_nxt  = borrow_word;
        overrun_nxt = overrun | ((state == RUN) & start);
        busy_nxt    = (state_nxt == RUN);
        done_nxt    = (state_nxt == DONE);
        if (take_bit) begin
            d_nxt     = bit_d;
            bout_nxt  = bit_br;
            shreg_nxt = {bit_d, shreg[WIDTH-1:1]};
            cnt_nxt   = first_bit ? CW'(1) : cnt + CW'(1);
        end
        if (last_bit) begin
            diff_nxt   = {bit_d, shreg[WIDTH-1:1]};
            borrow_nxt = bit_br;
            cnt_nxt    = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            shreg       <= '0;
            d           <= 1'b0;
            bout        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            diff_word   <= '0;
            borrow_word <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            shreg       <= shreg_nxt;
            d           <= d_nxt;
            bout        <= bout_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            diff_word   <= diff_nxt;
            borrow_word <= borrow_nxt;
            overrun     <= overrun_nxt;
        end
    end

endmodule
